// File: rtl/line_fetch_buffer_pkg.sv
// Shared constants and helpers for the fetch-side line buffer and the RAM wrapper.
// Port A/B address widths live here so both sides agree on them.
package line_fetch_buffer_pkg;

  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int IDX_W          = 2;
  localparam int PORTA_AW       = 14;
  localparam int PORTB_AW       = PORTA_AW - IDX_W;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FILL = 2'd1;
  localparam state_t CAPT = 2'd2;
  localparam state_t RESP = 2'd3;

  function automatic logic [WORD_W-1:0] line_word_sel(input logic [LINE_W-1:0] line,
                                                      input logic [IDX_W-1:0]  idx);
    logic [WORD_W-1:0] word;
    case (idx)
      2'd0:    word = line[0*WORD_W +: WORD_W];
      2'd1:    word = line[1*WORD_W +: WORD_W];
      2'd2:    word = line[2*WORD_W +: WORD_W];
      default: word = line[3*WORD_W +: WORD_W];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/line_fetch_buffer_if.sv
// Fetch-stage request/response and RAM port B signals of the line fetch buffer.
// slave is the buffer's view; master is the environment's view.
interface line_fetch_buffer_if
  import line_fetch_buffer_pkg::*;
#(
  parameter int WAW = PORTA_AW
);

  logic              f_req;
  logic [WAW-1:0]    f_addr;
  logic              f_ack;
  logic [WORD_W-1:0] f_data;
  logic              flush;
  logic              mem_en;
  logic [WAW-3:0]    mem_addr;
  logic [LINE_W-1:0] mem_q;

  modport slave (
    input  f_req, f_addr, flush, mem_q,
    output f_ack, f_data, mem_en, mem_addr
  );

  modport master (
    output f_req, f_addr, flush, mem_q,
    input  f_ack, f_data, mem_en, mem_addr
  );

endinterface

// File: rtl/line_fetch_buffer_word_mux.sv
// 4:1 word selector out of a 128-bit line; shared by the hit and fill paths.
module line_word_mux
  import line_fetch_buffer_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [WORD_W-1:0] word_o
);

  assign word_o = line_word_sel(line_i, idx_i);

endmodule

// File: rtl/line_fetch_buffer.sv
// Turns 32-bit instruction fetches into 128-bit port B line reads, keeping the
// last fetched line in a one-entry buffer so sequential fetches hit.
module line_fetch_buffer
  import line_fetch_buffer_pkg::*;
#(
  parameter int WAW = PORTA_AW,
  localparam int LAW = WAW - IDX_W
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst_n,
  line_fetch_buffer_if.slave  bus
);

  state_t            state_q,      state_d;
  logic              line_valid_q, line_valid_d;
  logic [LAW-1:0]    tag_q,        tag_d;
  logic [LINE_W-1:0] line_q,       line_d;
  logic [WORD_W-1:0] f_data_q,     f_data_d;
  logic [LAW-1:0]    mem_addr_q,   mem_addr_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic              flush_pend_q, flush_pend_d;

  logic              hit;
  logic [WORD_W-1:0] hit_word;
  logic [WORD_W-1:0] fill_word;

  line_word_mux u_hit_mux (
    .line_i (line_q),
    .idx_i  (bus.f_addr[IDX_W-1:0]),
    .word_o (hit_word)
  );

  line_word_mux u_fill_mux (
    .line_i (bus.mem_q),
    .idx_i  (idx_q),
    .word_o (fill_word)
  );

  // A flush in the same cycle as the request forces the miss path.
  assign hit = line_valid_q && (tag_q == bus.f_addr[WAW-1:IDX_W]) && !bus.flush;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d      = state_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    line_d       = line_q;
    f_data_d     = f_data_q;
    mem_addr_d   = mem_addr_q;
    idx_d        = idx_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      IDLE: begin
        if (bus.flush) line_valid_d = 1'b0;
        if (bus.f_req) begin
          if (hit) begin
            f_data_d = hit_word;
            state_d  = RESP;
          end else begin
            mem_addr_d = bus.f_addr[WAW-1:IDX_W];
            idx_d      = bus.f_addr[IDX_W-1:0];
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (bus.flush) flush_pend_d = 1'b1;
        state_d = CAPT;
      end
      CAPT: begin
        // A flush seen while the read was in flight still returns the data,
        // but the captured line must not be trusted for later hits.
        line_d       = bus.mem_q;
        tag_d        = mem_addr_q;
        line_valid_d = !(bus.flush || flush_pend_q);
        f_data_d     = fill_word;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.flush) line_valid_d = 1'b0;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      // NOTE: the line register is reset as well, so f_data never exposes stale contents after reset.
      line_q       <= '0;
      f_data_q     <= '0;
      mem_addr_q   <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      f_data_q     <= f_data_d;
      mem_addr_q   <= mem_addr_d;
      idx_q        <= idx_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.f_ack    = (state_q == RESP);
  assign bus.mem_en   = (state_q == FILL);
  assign bus.f_data   = f_data_q;
  assign bus.mem_addr = mem_addr_q;

endmodule
